// File: rtl/demux_lector.sv
// demux_lector
//   Drains an upstream FIFO and routes each word to one of two output
//   channels according to the word's most significant bit. A small FSM
//   governs when reads may be issued, honouring a global enable and
//   almost-full backpressure from both downstream channels.
//
// Ports
//   clk          : single clock, rising edge
//   reset        : asynchronous active-high reset
//   habilitar    : enables draining of the upstream FIFO
//   fifo_empty   : upstream FIFO empty flag
//   fifo_data    : upstream FIFO data_out, valid the cycle after a read
//   pausa0/1     : almost-full backpressure from channels 0 / 1
//   read_enable  : combinational pop request to the upstream FIFO
//   data_out0/1  : routed words (hold their value between pulses)
//   valid_out0/1 : one-cycle qualifiers for data_out0/1
//   cnt0/1       : per-channel delivered-word counters (wrap at 8 bits)
//   estado       : current FSM state encoding
module demux_lector #(
    parameter int tamano_datos = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    habilitar,
    input  logic                    fifo_empty,
    input  logic [tamano_datos-1:0] fifo_data,
    input  logic                    pausa0,
    input  logic                    pausa1,
    output logic                    read_enable,
    output logic [tamano_datos-1:0] data_out0,
    output logic [tamano_datos-1:0] data_out1,
    output logic                    valid_out0,
    output logic                    valid_out1,
    output logic [7:0]              cnt0,
    output logic [7:0]              cnt1,
    output logic [1:0]              estado
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACTIVE = 2'b01,
        PAUSE  = 2'b10
    } estado_t;

    estado_t est_q;
    estado_t est_d;
    logic    rd_q;
    logic    pausa;
    logic    sel;

    assign pausa  = pausa0 | pausa1;
    assign sel    = fifo_data[tamano_datos-1];
    assign estado = est_q;

    // Next-state and read request
    always_comb begin
        est_d       = est_q;
        read_enable = 1'b0;
        case (est_q)
            IDLE: begin
                if (habilitar && !fifo_empty)
                    est_d = ACTIVE;
            end
            ACTIVE: begin
                read_enable = habilitar && !fifo_empty && !pausa;
                if (!habilitar || fifo_empty)
                    est_d = IDLE;
                else if (pausa)
                    est_d = PAUSE;
            end
            PAUSE: begin
                if (!habilitar)
                    est_d = IDLE;
                else if (!pausa)
                    est_d = ACTIVE;
            end
            default: est_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            est_q <= IDLE;
        else
            est_q <= est_d;
    end

    // Read pipeline and routing. rd_q marks that fifo_data carries a freshly
    // popped word this cycle; it is delivered regardless of what the FSM
    // inputs do in the meantime.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_q       <= 1'b0;
            data_out0  <= '0;
            data_out1  <= '0;
            valid_out0 <= 1'b0;
            valid_out1 <= 1'b0;
            cnt0       <= '0;
            cnt1       <= '0;
        end else begin
            rd_q       <= read_enable;
            valid_out0 <= rd_q && !sel;
            valid_out1 <= rd_q && sel;
            if (rd_q && !sel) begin
                data_out0 <= fifo_data;
                cnt0      <= cnt0 + 8'd1;
            end
            if (rd_q && sel) begin
                data_out1 <= fifo_data;
                cnt1      <= cnt1 + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_demux_lector.sv
module tb_demux_lector;

    localparam int W = 10;

    logic         clk = 1'b0;
    logic         reset;
    logic         habilitar;
    logic         fifo_empty;
    logic [W-1:0] fifo_data;
    logic         pausa0;
    logic         pausa1;
    logic         read_enable;
    logic [W-1:0] data_out0;
    logic [W-1:0] data_out1;
    logic         valid_out0;
    logic         valid_out1;
    logic [7:0]   cnt0;
    logic [7:0]   cnt1;
    logic [1:0]   estado;

    demux_lector #(.tamano_datos(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .habilitar   (habilitar),
        .fifo_empty  (fifo_empty),
        .fifo_data   (fifo_data),
        .pausa0      (pausa0),
        .pausa1      (pausa1),
        .read_enable (read_enable),
        .data_out0   (data_out0),
        .data_out1   (data_out1),
        .valid_out0  (valid_out0),
        .valid_out1  (valid_out1),
        .cnt0        (cnt0),
        .cnt1        (cnt1),
        .estado      (estado)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] fifo_q[$];
    logic [W-1:0] exp0[$];
    logic [W-1:0] exp1[$];
    logic [7:0]   m_cnt0 = 8'd0;
    logic [7:0]   m_cnt1 = 8'd0;
    int           re_cnt = 0;
    int           v_cnt  = 0;
    logic         re_n   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Upstream FIFO model: a sampled read pops at the edge, data appears after it
    always @(negedge clk) re_n = read_enable;

    always @(posedge clk) begin
        logic pop;
        pop = !reset && re_n && (fifo_q.size() > 0);
        #1;
        if (pop) fifo_data = fifo_q.pop_front();
        fifo_empty = (fifo_q.size() == 0);
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        logic [W-1:0] w;
        if (!reset) begin
            if (read_enable) re_cnt++;
            if (valid_out0 && valid_out1) check("both_valid", 32'd1, 32'd0);
            if (valid_out0) begin
                v_cnt++;
                if (exp0.size() == 0) check("unexpected_valid0", {22'd0, data_out0}, 32'hFFFF_FFFF);
                else begin
                    w = exp0.pop_front();
                    m_cnt0 = m_cnt0 + 8'd1;
                    check("data_out0", {22'd0, data_out0}, {22'd0, w});
                    check("cnt0", {24'd0, cnt0}, {24'd0, m_cnt0});
                end
            end
            if (valid_out1) begin
                v_cnt++;
                if (exp1.size() == 0) check("unexpected_valid1", {22'd0, data_out1}, 32'hFFFF_FFFF);
                else begin
                    w = exp1.pop_front();
                    m_cnt1 = m_cnt1 + 8'd1;
                    check("data_out1", {22'd0, data_out1}, {22'd0, w});
                    check("cnt1", {24'd0, cnt1}, {24'd0, m_cnt1});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [W-1:0] w, input int ch);
        fifo_q.push_back(w);
        if (ch == 0) exp0.push_back(w);
        else exp1.push_back(w);
    endtask

    task automatic wait_re(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (read_enable) begin
                seen = 1'b1;
                break;
            end
        end
        check(name, {31'd0, seen}, 32'd1);
    endtask

    task automatic drain(input string name, input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (fifo_q.size() == 0 && exp0.size() == 0 && exp1.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        check(name, {31'd0, done}, 32'd1);
        repeat (3) tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_estado"}, {30'd0, estado}, 32'd0);
        check({tag, "_re"}, {31'd0, read_enable}, 32'd0);
        check({tag, "_d0"}, {22'd0, data_out0}, 32'd0);
        check({tag, "_d1"}, {22'd0, data_out1}, 32'd0);
        check({tag, "_v"}, {30'd0, valid_out1, valid_out0}, 32'd0);
        check({tag, "_cnt"}, {16'd0, cnt1, cnt0}, 32'd0);
    endtask

    initial begin
        int re0;
        int v0;
        fifo_data  = '0;
        fifo_empty = 1'b1;
        reset      = 1'b1;
        habilitar  = 1'b0;
        pausa0     = 1'b0;
        pausa1     = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset");
        reset = 1'b0;
        tick();

        // Two words, routed to channel 1 then channel 0, cycle-exact latency
        load(10'h205, 1);
        load(10'h00A, 0);
        repeat (2) tick();
        habilitar = 1'b1;
        wait_re("t28_first_re");
        @(negedge clk);
        check("t28_re_t1", {31'd0, read_enable}, 32'd1);
        @(negedge clk);
        check("t28_re_t2", {31'd0, read_enable}, 32'd0);
        check("t28_v1_t2", {30'd0, valid_out1, valid_out0}, 32'd2);
        check("t28_d1_t2", {22'd0, data_out1}, 32'h205);
        @(negedge clk);
        check("t28_v0_t3", {30'd0, valid_out1, valid_out0}, 32'd1);
        check("t28_d0_t3", {22'd0, data_out0}, 32'h00A);
        check("t28_d1_hold", {22'd0, data_out1}, 32'h205);
        check("t28_cnts", {16'd0, cnt1, cnt0}, 32'h0101);
        drain("t28_drain", 20);
        check("t28_idle", {30'd0, estado}, 32'd0);

        // Backpressure while reading
        habilitar = 1'b0;
        load(10'h010, 0);
        load(10'h211, 1);
        load(10'h012, 0);
        load(10'h213, 1);
        repeat (2) tick();
        habilitar = 1'b1;
        wait_re("t29_first_re");
        tick();
        pausa0 = 1'b1;
        @(negedge clk);
        check("t29_re_off", {31'd0, read_enable}, 32'd0);
        check("t29_still_active", {30'd0, estado}, 32'd1);
        tick();
        @(negedge clk);
        check("t29_pause", {30'd0, estado}, 32'd2);
        repeat (3) tick();
        pausa0 = 1'b0;
        @(negedge clk);
        check("t29_pause_hold", {30'd0, estado}, 32'd2);
        @(negedge clk);
        check("t29_resume", {30'd0, estado}, 32'd1);
        drain("t29_drain", 30);

        // habilitar dropped while active
        habilitar = 1'b0;
        load(10'h3FF, 1);
        load(10'h000, 0);
        load(10'h155, 0);
        load(10'h2AA, 1);
        repeat (2) tick();
        habilitar = 1'b1;
        wait_re("t33_first_re");
        tick();
        habilitar = 1'b0;
        @(negedge clk);
        check("t33_re_off", {31'd0, read_enable}, 32'd0);
        tick();
        @(negedge clk);
        check("t33_idle", {30'd0, estado}, 32'd0);
        repeat (4) tick();
        check("t33_pending_delivered", exp0.size() + exp1.size(), fifo_q.size());
        habilitar = 1'b1;
        drain("t33_drain", 30);

        // Empty FIFO with enable: nothing happens
        re0 = re_cnt;
        v0  = v_cnt;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("t30_idle", {30'd0, estado}, 32'd0);
        end
        check("t30_no_re", re_cnt - re0, 32'd0);
        check("t30_no_valid", v_cnt - v0, 32'd0);

        // Reset while a word is in flight
        habilitar = 1'b0;
        load(10'h001, 0);
        load(10'h202, 1);
        load(10'h003, 0);
        load(10'h204, 1);
        repeat (2) tick();
        habilitar = 1'b1;
        wait_re("t32_first_re");
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("t32_async");
        fifo_q.delete();
        exp0.delete();
        exp1.delete();
        m_cnt0 = 8'd0;
        m_cnt1 = 8'd0;
        habilitar = 1'b0;
        repeat (2) tick();
        v0 = v_cnt;
        reset = 1'b0;
        repeat (6) tick();
        check("t32_no_valid", v_cnt - v0, 32'd0);
        check("t32_cnts", {16'd0, cnt1, cnt0}, 32'd0);

        // 256 words to channel 0: counter wraps
        for (int i = 0; i < 256; i++) begin
            logic [W-1:0] w;
            w = W'(i);
            load(w, 0);
        end
        repeat (2) tick();
        habilitar = 1'b1;
        drain("t31_drain", 400);
        check("t31_cnt0_wrap", {24'd0, cnt0}, 32'd0);
        check("t31_cnt1", {24'd0, cnt1}, 32'd0);
        check("t31_last_d0", {22'd0, data_out0}, 32'h0FF);

        habilitar = 1'b0;
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/demux_lector.md
DEMUX_LECTOR -- requirements
Module: demux_lector

Interface
REQ-001 The block SHALL have parameter tamano_datos, default 10, meaning the width of a FIFO word and of each output channel.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port habilitar, input, 1, enables draining of the upstream FIFO.
REQ-005 The block SHALL have port fifo_empty, input, 1, the upstream FIFO empty flag.
REQ-006 The block SHALL have port fifo_data, input, tamano_datos, the upstream FIFO data_out, valid the cycle after read_enable is sampled high.
REQ-007 The block SHALL have ports pausa0 and pausa1, input, 1 each, almost-full backpressure from downstream channels 0 and 1.
REQ-008 The block SHALL have port read_enable, output, 1, the pop request to the upstream FIFO.
REQ-009 The block SHALL have ports data_out0 and data_out1, output, tamano_datos each, the routed words.
REQ-010 The block SHALL have ports valid_out0 and valid_out1, output, 1 each, one-cycle qualifiers for data_out0 and data_out1.
REQ-011 The block SHALL have ports cnt0 and cnt1, output, 8 each, per-channel delivered-word counters.
REQ-012 The block SHALL have port estado, output, 2, current FSM state encoding.

Function
REQ-013 The FSM SHALL have states IDLE=2'b00, ACTIVE=2'b01, PAUSE=2'b10; 2'b11 is illegal and SHALL go to IDLE.
REQ-014 IDLE SHALL go to ACTIVE when habilitar=1 and fifo_empty=0; otherwise stay IDLE.
REQ-015 ACTIVE SHALL go to IDLE when habilitar=0 or fifo_empty=1, else to PAUSE when pausa0=1 or pausa1=1, else stay ACTIVE; IDLE takes priority over PAUSE.
REQ-016 PAUSE SHALL go to IDLE when habilitar=0, else to ACTIVE when pausa0=0 and pausa1=0, else stay PAUSE.
REQ-017 read_enable SHALL be combinational: 1 only when estado=ACTIVE, habilitar=1, fifo_empty=0, pausa0=0 and pausa1=0.
REQ-018 A registered flag rd_q SHALL capture read_enable each edge; when rd_q=1 the word on fifo_data SHALL be routed at the next edge.
REQ-019 Routing SHALL use fifo_data[tamano_datos-1]: 0 -> channel 0, 1 -> channel 1; the full word, including the select bit, SHALL be passed unmodified.
REQ-020 The selected data_outN SHALL load fifo_data and valid_outN SHALL be 1 for exactly one cycle; the other channel's data SHALL hold and its valid SHALL be 0.
REQ-021 Latency SHALL be 2 cycles: read_enable high in cycle t gives valid_outN high in cycle t+2; back-to-back reads SHALL give back-to-back valids.
REQ-022 A word already in flight (rd_q=1) SHALL be delivered even if pausa, habilitar or fifo_empty change in that cycle.
REQ-023 cntN SHALL increment by 1 on each valid_outN pulse and SHALL wrap from 8'hFF to 8'h00.
REQ-024 data_outN SHALL hold its last value while valid_outN=0.

Reset
REQ-025 While reset=1, asynchronously: estado=IDLE, rd_q=0, data_out0=data_out1=0, valid_out0=valid_out1=0, cnt0=cnt1=0, read_enable=0.
REQ-026 Reset asserted mid-operation SHALL discard any in-flight word; no valid pulse SHALL follow reset release.
REQ-027 After reset release the first transition out of IDLE SHALL follow REQ-014.

Verification
REQ-028 FIFO holds 10'h205 then 10'h00A, habilitar=1, no pausa -> read_enable high cycles t and t+1; valid_out1=1 with data_out1=10'h205 at t+2; valid_out0=1 with data_out0=10'h00A at t+3; cnt1=1, cnt0=1.
REQ-029 pausa0 raised in cycle where read_enable=1 -> read_enable=0 same cycle, estado=PAUSE next cycle, in-flight word still delivered 2 cycles after last read; pausa0 lowered -> ACTIVE next cycle.
REQ-030 fifo_empty=1, habilitar=1 -> read_enable=0 always, estado=IDLE, no valid pulses.
REQ-031 256 words with MSB=0 -> cnt0 reaches 8'hFF then wraps to 8'h00; cnt1 stays 0.
REQ-032 reset pulsed while rd_q=1 -> all outputs 0 immediately, no valid pulse after release, cnt0=cnt1=0.
REQ-033 habilitar dropped in ACTIVE -> read_enable=0 same cycle, estado=IDLE next cycle, pending word delivered.
